warp_fetcher: RTL

- Per-warp instruction fetch stage, directly upstream of the warp's decoder.
- Sees the warp controller in WARP_FETCH, reads the 32-bit instruction at the warp's byte PC from program memory over a valid/ready handshake, then holds it stable on `instruction` through WARP_DECODE.
- A single-entry last-fetch buffer skips the memory access when the same PC is fetched again, e.g. loop back-edges and SYNC re-issue.

---
 rtl/warp_fetcher.sv | 127 ++++++++++++
 1 files changed

// File: rtl/warp_fetcher.sv
// Per-warp instruction fetch stage: reads one instruction per WARP_FETCH over a
// valid/ready program-memory port, with a single-entry last-fetch buffer.
package warp_fetcher_pkg;
  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_REQUEST,
    WARP_WAIT,
    WARP_EXECUTE,
    WARP_UPDATE,
    WARP_DONE
  } warp_state_t;

  typedef enum logic [1:0] {
    FETCHER_IDLE,
    FETCHER_FETCHING,
    FETCHER_DONE
  } fetcher_state_t;
endpackage

module warp_fetcher
  import warp_fetcher_pkg::*;
#(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PC_WIDTH              = 32,
  parameter int INSTRUCTION_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  warp_state_t                      warp_state,
  input  logic [PC_WIDTH-1:0]              pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [INSTRUCTION_WIDTH-1:0]     mem_read_data,
  output fetcher_state_t                   fetcher_state,
  output logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic                             fetch_error
);

  fetcher_state_t                   state_n;
  logic                             valid_n;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_n;
  logic [INSTRUCTION_WIDTH-1:0]     instr_n;
  logic                             err_n;
  logic [PC_WIDTH-1:0]              req_pc, req_pc_n;
  logic                             buf_valid, buf_valid_n;
  logic [PC_WIDTH-1:0]              buf_pc, buf_pc_n;
  logic [INSTRUCTION_WIDTH-1:0]     buf_data, buf_data_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetcher_state    <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      fetch_error      <= 1'b0;
      req_pc           <= '0;
      buf_valid        <= 1'b0;
      buf_pc           <= '0;
      buf_data         <= '0;
    end else begin
      fetcher_state    <= state_n;
      mem_read_valid   <= valid_n;
      mem_read_address <= addr_n;
      instruction      <= instr_n;
      fetch_error      <= err_n;
      req_pc           <= req_pc_n;
      buf_valid        <= buf_valid_n;
      buf_pc           <= buf_pc_n;
      buf_data         <= buf_data_n;
    end
  end

  // Every output is registered, so this block computes next values only.
  always_comb begin
    state_n     = fetcher_state;
    valid_n     = mem_read_valid;
    addr_n      = mem_read_address;
    instr_n     = instruction;
    err_n       = 1'b0;
    req_pc_n    = req_pc;
    buf_valid_n = buf_valid;
    buf_pc_n    = buf_pc;
    buf_data_n  = buf_data;

    unique case (fetcher_state)
      FETCHER_IDLE: begin
        if (warp_state == WARP_FETCH) begin
          if (pc[1:0] != 2'b00) begin
            err_n   = 1'b1;
            instr_n = '0;
            state_n = FETCHER_DONE;
          end else if (buf_valid && !invalidate && buf_pc == pc) begin
            instr_n = buf_data;
            state_n = FETCHER_DONE;
          end else begin
            valid_n  = 1'b1;
            addr_n   = pc[PROGRAM_MEM_ADDR_BITS+1:2];
            req_pc_n = pc;
            state_n  = FETCHER_FETCHING;
          end
        end
      end
      FETCHER_FETCHING: begin
        if (mem_read_ready) begin
          instr_n     = mem_read_data;
          buf_data_n  = mem_read_data;
          buf_pc_n    = req_pc;
          buf_valid_n = 1'b1;
          valid_n     = 1'b0;
          state_n     = FETCHER_DONE;
        end
      end
      FETCHER_DONE: begin
        if (warp_state == WARP_DECODE) state_n = FETCHER_IDLE;
      end
      default: state_n = FETCHER_IDLE;
    endcase

    // A program reload beats a buffer fill landing in the same cycle.
    if (invalidate) buf_valid_n = 1'b0;
  end

endmodule
